// File: rtl/axis_accum_responder_if.sv
// axis_accum_responder_if: AXI-Lite control bus plus AXI-Stream in/out.
// master = bus driver / stream source+sink side, slave = responder side.
interface axis_accum_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              ss_tvalid;
  logic              ss_tready;
  logic [DATA_W-1:0] ss_tdata;
  logic              ss_tlast;
  logic              sm_tvalid;
  logic              sm_tready;
  logic [DATA_W-1:0] sm_tdata;
  logic              sm_tlast;

  modport master (
    output awvalid, awaddr, wvalid, wdata,
    output arvalid, araddr, rready,
    output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  awready, wready, arready, rvalid, rdata,
    input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata,
    input  arvalid, araddr, rready,
    input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output awready, wready, arready, rvalid, rdata,
    output ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/axis_accum_responder.sv
// axis_accum_responder: y[n] = y[n-1] + x[n]*SCALE with ap_start/done/idle.
// Ports: axis_clk, axis_rst_n (async, low), bus (AXI-Lite + ss/sm streams).
// Optional: define ACC_SATURATE_EN for saturating sum and CTRL bit8 flag.
module axis_accum_responder #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 2
) (
  input logic                   axis_clk,
  input logic                   axis_rst_n,
  axis_accum_responder_if.slave bus
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [PW+1:0] DEPTH_L = (PW+2)'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic              aw_got, w_got;
  logic [7:0]        wa_q;
  logic [DATA_W-1:0] wd_q;
  logic              ar_rdy_q, rvalid_q, ar_wait;
  logic [DATA_W-1:0] rdata_q, rd_mux, ctrl;
  logic [DATA_W-1:0] length_q, scale_q, count_q;
  logic [DATA_W-1:0] acc_q, acc_nxt;
  logic              ap_done_q, ap_idle_q;
  logic              push_v, push_last;
  logic [DATA_W:0]   mem [OUT_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [PW:0]       occ_q;
  logic [PW+1:0]     lvl;
  logic              sm_valid, pop, ss_rdy, ss_fire;
  logic              wr_pend, wr_en, ar_fire, rd_clr, start_wr;
  logic              sat_bit;
  logic              unused_ok;

  assign unused_ok = ^{bus.awaddr[ADDR_W-1:8],
                       bus.araddr[ADDR_W-1:8], bus.ss_tlast};

  // Write channel: each half is held until its partner arrives.
  assign wr_pend     = aw_got && w_got;
  assign bus.awready = !aw_got;
  assign bus.wready  = !w_got;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else if (wr_pend) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (bus.awvalid && !aw_got) begin
        aw_got <= 1'b1;
        wa_q   <= bus.awaddr[7:0];
      end
      if (bus.wvalid && !w_got) begin
        w_got <= 1'b1;
        wd_q  <= bus.wdata;
      end
    end
  end

  // Read channel: data is sampled at accept, so a same-edge write or
  // read-clear of CTRL is not yet visible in rdata.
  assign ar_fire     = bus.arvalid && ar_rdy_q;
  assign rd_clr      = ar_fire && (bus.araddr[7:0] == 8'h00);
  assign bus.arready = ar_rdy_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ar_rdy_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ar_wait  <= 1'b0;
    end else begin
      ar_wait <= 1'b0;
      if (ar_fire) begin
        ar_rdy_q <= 1'b0;
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end
      if (rvalid_q && bus.rready) begin
        rvalid_q <= 1'b0;
        ar_wait  <= 1'b1;
      end
      if (ar_wait) ar_rdy_q <= 1'b1;
    end
  end

  always_comb begin
    ctrl    = '0;
    ctrl[1] = ap_done_q;
    ctrl[2] = ap_idle_q;
    ctrl[4] = ss_rdy;
    ctrl[5] = sm_valid;
    ctrl[8] = sat_bit;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      bus.araddr[7:0] == 8'h00: rd_mux = ctrl;
      bus.araddr[7:0] == 8'h10: rd_mux = length_q;
      bus.araddr[7:0] == 8'h14: rd_mux = scale_q;
      bus.araddr[7:0] == 8'h18: rd_mux = count_q;
      default:                  rd_mux = '0;
    endcase
  end

  // Stream side. The level counts the in-flight push and a same-cycle pop
  // so the buffer can never overflow yet still sustains 1 sample/cycle.
  assign sm_valid = occ_q != '0;
  assign pop      = sm_valid && bus.sm_tready;
  assign lvl      = {1'b0, occ_q} + {{(PW+1){1'b0}}, push_v}
                  - {{(PW+1){1'b0}}, pop};
  assign ss_rdy   = (state_q == RUN) && (lvl < DEPTH_L)
                  && (count_q < length_q);
  assign ss_fire  = bus.ss_tvalid && ss_rdy;

  assign bus.ss_tready = ss_rdy;
  assign bus.sm_tvalid = sm_valid;
  assign bus.sm_tdata  = sm_valid ? mem[rp][DATA_W-1:0] : '0;
  assign bus.sm_tlast  = sm_valid && mem[rp][DATA_W];

`ifdef ACC_SATURATE_EN
  logic signed [2*DATA_W-1:0] prod;
  logic [2*DATA_W:0]          sum;
  logic                       ovf, sat_q;

  assign prod = $signed(bus.ss_tdata) * $signed(scale_q);
  assign sum  = {{(DATA_W+1){acc_q[DATA_W-1]}}, acc_q}
              + {prod[2*DATA_W-1], prod};
  assign ovf  = !(&sum[2*DATA_W:DATA_W-1])
              && (|sum[2*DATA_W:DATA_W-1]);
  assign acc_nxt = !ovf ? sum[DATA_W-1:0] :
                   sum[2*DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
  assign sat_bit = sat_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) sat_q <= 1'b0;
    else begin
      if (rd_clr) sat_q <= 1'b0;
      if (state_q == IDLE && state_d == RUN) sat_q <= 1'b0;
      if (ss_fire && ovf) sat_q <= 1'b1;
    end
  end
`else
  assign acc_nxt = acc_q + bus.ss_tdata * scale_q;
  assign sat_bit = 1'b0;
`endif

  assign wr_en    = wr_pend && (state_q != RUN);
  assign start_wr = wr_en && (wa_q == 8'h00) && wd_q[0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_wr)
              state_d = (length_q != '0) ? RUN : DONE;
      RUN:  if (pop && bus.sm_tlast) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      length_q  <= '0;
      scale_q   <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      ap_done_q <= 1'b0;
      ap_idle_q <= 1'b1;
      push_v    <= 1'b0;
      push_last <= 1'b0;
    end else begin
      if (rd_clr) ap_done_q <= 1'b0;
      if (wr_en) begin
        if (wa_q == 8'h10) length_q <= wd_q;
        if (wa_q == 8'h14) scale_q  <= wd_q;
      end
      push_v <= ss_fire;
      if (ss_fire) begin
        acc_q     <= acc_nxt;
        count_q   <= count_q + 1'b1;
        push_last <= (count_q + 1'b1) == length_q;
      end
      if (state_q == IDLE && state_d == RUN) begin
        acc_q     <= '0;
        count_q   <= '0;
        ap_idle_q <= 1'b0;
        ap_done_q <= 1'b0;
      end
      if (state_q != DONE && state_d == DONE) begin
        ap_done_q <= 1'b1;
        ap_idle_q <= 1'b1;
      end
    end
  end

  // Output buffer: acc is pushed one cycle after the accepting edge.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      occ_q <= '0;
    end else begin
      if (push_v) begin
        mem[wp] <= {push_last, acc_q};
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      occ_q <= occ_q + {{PW{1'b0}}, push_v} - {{PW{1'b0}}, pop};
    end
  end
endmodule

// File: tb/tb_axis_accum_responder.sv
// tb_axis_accum_responder: directed bench with queue scoreboard for
// the sm stream and AXI-Lite read data.
module tb_axis_accum_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_accum_responder_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  axis_accum_responder #(
    .ADDR_W(12), .DATA_W(32), .OUT_DEPTH(2)
  ) dut (
    .axis_clk  (clk),
    .axis_rst_n(rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] sq[$];
  logic [31:0] rq[$];

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void tmo(string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout got none expected handshake", name);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_extra: got %h expected none", bus.rdata);
        end else chk("rdata", {32'h0, bus.rdata}, {32'h0, rq.pop_front()});
      end
      if (bus.sm_tvalid && bus.sm_tready) begin
        if (sq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sm_extra: got %h expected none", bus.sm_tdata);
        end else chk("sm_out", {31'h0, bus.sm_tlast, bus.sm_tdata},
                     {31'h0, sq.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    logic ok;
    bus.awaddr = a;
    bus.wdata = d;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.awready && bus.wready;
      tick();
      n++;
    end while (!ok && n < 50);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    if (!ok) tmo("wr");
    tick();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    int n = 0;
    logic ok;
    rq.push_back(e);
    bus.araddr = a;
    bus.arvalid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.arready;
      tick();
      n++;
    end while (!ok && n < 50);
    bus.arvalid = 1'b0;
    if (!ok) tmo("rd_ar");
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.rvalid;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) tmo("rd_r");
    tick();
  endtask

  task automatic send(input logic [31:0] x);
    int n = 0;
    logic ok;
    bus.ss_tdata = x;
    bus.ss_tvalid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.ss_tready;
      tick();
      n++;
    end while (!ok && n < 100);
    bus.ss_tvalid = 1'b0;
    if (!ok) tmo("send");
  endtask

  task automatic drain();
    int n = 0;
    while (sq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sq.size() != 0) tmo("drain");
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.awvalid = 1'b0;
    bus.awaddr = '0;
    bus.wvalid = 1'b0;
    bus.wdata = '0;
    bus.arvalid = 1'b0;
    bus.araddr = '0;
    bus.rready = 1'b1;
    bus.ss_tvalid = 1'b0;
    bus.ss_tdata = '0;
    bus.ss_tlast = 1'b0;
    bus.sm_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_ss_tready", bus.ss_tready, 0);
    chk("rst_sm", {bus.sm_tvalid, bus.sm_tlast, bus.sm_tdata}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    wr(12'h010, 4);
    wr(12'h014, 3);
    rd(12'h010, 4);
    rd(12'h014, 3);
    rd(12'h000, 32'h4);

    sq.push_back({1'b0, 32'd3});
    sq.push_back({1'b0, 32'd9});
    sq.push_back({1'b0, 32'd18});
    sq.push_back({1'b1, 32'd30});
    wr(12'h000, 1);
    send(1); send(2); send(3); send(4);
    drain();
    rd(12'h000, 32'h6);
    rd(12'h000, 32'h4);
    rd(12'h018, 4);

    wr(12'h010, 6);
    wr(12'h014, 2);
    sq.push_back({1'b0, 32'd10});
    sq.push_back({1'b0, 32'd8});
    sq.push_back({1'b0, 32'd22});
    sq.push_back({1'b0, 32'd22});
    sq.push_back({1'b0, 32'd28});
    sq.push_back({1'b1, 32'd48});
    wr(12'h000, 1);
    fork
      begin
        send(5); send(32'hFFFF_FFFF); send(7);
        send(0); send(3); send(10);
      end
      begin
        repeat (3) tick();
        bus.sm_tready = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("stall_ss_tready", bus.ss_tready, 0);
        chk("stall_sm_tvalid", bus.sm_tvalid, 1);
        tick();
        bus.sm_tready = 1'b1;
      end
    join
    drain();
    rd(12'h000, 32'h6);
    rd(12'h000, 32'h4);

    bus.awaddr = 12'h014;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.awaddr = 12'h010;
    @(negedge clk);
    chk("split_aw_held", {bus.awready, bus.wready}, 2'b01);
    tick();
    tick();
    bus.wdata = 5;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    tick();
    tick();
    chk("split_ready_back", {bus.awready, bus.wready}, 2'b11);
    rd(12'h014, 5);
    rd(12'h010, 6);
    wr(12'h040, 32'hDEAD_BEEF);
    rd(12'h040, 0);
    rd(12'h010, 6);
    rd(12'h014, 5);

    wr(12'h010, 0);
    wr(12'h000, 1);
    rd(12'h000, 32'h6);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.sm_tvalid) seen = 1'b1;
    end
    chk("len0_no_output", seen, 0);
    tick();
    rd(12'h000, 32'h4);

    wr(12'h010, 2);
    wr(12'h014, 32'h7FFF_FFFF);
`ifdef ACC_SATURATE_EN
    sq.push_back({1'b0, 32'h7FFF_FFFF});
    sq.push_back({1'b1, 32'h7FFF_FFFF});
`else
    sq.push_back({1'b0, 32'hFFFF_FFFE});
    sq.push_back({1'b1, 32'hFFFF_FFFC});
`endif
    wr(12'h000, 1);
    send(2); send(2);
    drain();
`ifdef ACC_SATURATE_EN
    rd(12'h000, 32'h106);
`else
    rd(12'h000, 32'h6);
`endif
    rd(12'h000, 32'h4);

    wr(12'h010, 4);
    wr(12'h014, 1);
    wr(12'h000, 1);
    bus.sm_tready = 1'b0;
    send(7); send(8);
    repeat (2) tick();
    @(negedge clk);
    chk("mid_run_buffered", bus.sm_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sm", {bus.sm_tvalid, bus.sm_tlast, bus.sm_tdata}, 0);
    chk("arst_ss_tready", bus.ss_tready, 0);
    chk("arst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("arst_rvalid", bus.rvalid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.sm_tready = 1'b1;
    tick();
    rd(12'h000, 32'h4);
    rd(12'h010, 0);
    wr(12'h010, 3);
    wr(12'h014, 32'hFFFF_FFFE);
    sq.push_back({1'b0, 32'hFFFF_FFFE});
    sq.push_back({1'b0, 32'hFFFF_FFFA});
    sq.push_back({1'b1, 32'hFFFF_FFF4});
    wr(12'h000, 1);
    send(1); send(2); send(3);
    drain();
    rd(12'h000, 32'h6);

    chk("sb_sm_empty", sq.size(), 0);
    chk("sb_rd_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_accum_responder.md
Name: axis_accum_responder

Overview:
- Responder end of the user-project bus bridge. Provides an AXI-Lite slave for control and status, an AXI-Stream slave for input samples, and an AXI-Stream master for output samples.
- Computes a scaled running sum, y[n] = y[n-1] + x[n]*scale. A 2-entry skid buffer on the output decouples the MAC stage from back-pressure.
- Same ap_start/ap_done/ap_idle control model as the FIR engine, so firmware drives both blocks identically.

Parameters:
- ADDR_W, 12, AXI-Lite address width
- DATA_W, 32, data, register and stream width
- OUT_DEPTH, 2, output buffer entries (power of 2, >=2)

Ports:
- axis_clk  in  1  sole clock
- axis_rst_n  in  1  reset, asynchronous assert, active-low
- awvalid/awready  in/out  1/1  write-address handshake
- awaddr  in  ADDR_W  write address
- wvalid/wready  in/out  1/1  write-data handshake
- wdata  in  DATA_W  write data
- arvalid/arready  in/out  1/1  read-address handshake
- araddr  in  ADDR_W  read address
- rvalid/rready  out/in  1/1  read-data handshake
- rdata  out  DATA_W  read data
- ss_tvalid/ss_tready  in/out  1/1  input stream handshake
- ss_tdata  in  DATA_W  input sample, signed
- ss_tlast  in  1  ignored unless the optional feature is enabled
- sm_tvalid/sm_tready  out/in  1/1  output stream handshake
- sm_tdata  out  DATA_W  output sample, signed
- sm_tlast  out  1  high on the final output sample

Behaviour:
- Reset values:
  - awready=wready=arready=1
  - rvalid=0, rdata=0, ss_tready=0, sm_tvalid=0, sm_tdata=0, sm_tlast=0
  - All registers 0, ap_idle=1, state IDLE
- Register map (word-aligned; decode awaddr/araddr[7:0]):
  - 0x00 CTRL: bit0 ap_start (write 1 to start, self-clearing, reads 0); bit1 ap_done (RO, cleared by a read of 0x00); bit2 ap_idle (RO); bit4 = ss_tready; bit5 = sm_tvalid.
  - 0x10 LENGTH: number of samples, RW.
  - 0x14 SCALE: signed multiplier, RW.
  - 0x18 COUNT: samples accepted in the current run, RO.
  - Any other address reads 0; writes to it are dropped.
- AXI-Lite write:
  - awready/wready idle high, so a same-cycle awvalid&&wvalid is accepted in that cycle.
  - If only one channel is valid, latch it and drop that channel's ready until the other arrives.
  - The register update occurs one cycle after both are captured. Both readies return high the following cycle.
  - No write-response channel.
- AXI-Lite read:
  - arready idle high. On accept, drop arready.
  - Next cycle rvalid=1 with rdata; hold both until rready.
  - One cycle after the rvalid&&rready handshake, arready returns to 1.
  - A read of 0x00 returns the pre-clear ap_done, then clears it.
- Simultaneous read and write to 0x00 in one cycle: the read returns the old value; the write applies.
- FSM:
  - IDLE -> RUN on ap_start write with LENGTH>0. Clear acc and COUNT, ap_idle=0, ap_done=0.
  - IDLE -> DONE on ap_start with LENGTH==0. ap_done=1 in the next cycle; no stream traffic occurs.
  - RUN: ss_tready = (output buffer not full) && (COUNT<LENGTH).
    - On ss_tvalid&&ss_tready: acc <= acc + ss_tdata*SCALE, keeping the low DATA_W bits (wrap).
    - Push the new acc into the output buffer the next cycle; increment COUNT.
    - The entry whose COUNT==LENGTH carries tlast=1.
  - RUN -> DONE when the tlast entry is handshaked on sm.
  - DONE -> IDLE next cycle. ap_done=1 and ap_idle=1 are set on entry.
- Input-to-output latency: 2 cycles when sm_tready is held high. Full throughput is 1 sample/cycle.
- Output buffer:
  - sm_tvalid = not empty. Simultaneous push and pop keeps the occupancy.
  - Read and write pointers wrap modulo OUT_DEPTH.
  - Never overflows, because ss_tready deasserts when the buffer holds OUT_DEPTH-1 entries and a push is in flight.
- Ignored while RUN: writes to LENGTH, SCALE and ap_start. Reads are still serviced.
- Reset mid-run: all state returns to reset values immediately. Buffered samples are discarded.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: the product is computed at 2*DATA_W bits and the sum saturates to 0x7FFFFFFF / 0x80000000 instead of wrapping. CTRL bit8 (sticky, cleared on a read of 0x00) flags that saturation occurred.
- Undefined: two's-complement wrap; bit8 reads 0.

Test Plan:
- Write LENGTH=4 and SCALE=3, read both back; read 0x00 -> ap_idle=1 (0x00000004).
- ap_start, stream 1,2,3,4 with sm_tready=1 -> outputs 3,9,18,30; sm_tlast only on 30; ap_done read=1 (0x00000006), then a second read shows it cleared (0x00000004).
- sm_tready low for 10 cycles mid-run -> ss_tready drops after the buffer fills; no sample lost or duplicated; output sequence unchanged.
- awvalid one cycle, wvalid 3 cycles later -> a single register update to the correct address; address 0x40 reads 0.
- LENGTH=0 then ap_start -> ap_done=1 within 2 cycles; sm_tvalid never asserts.
- SCALE=0x7FFFFFFF with input 2, 2 -> wraps (0xFFFFFFFE, 0xFFFFFFFC) without the macro; saturates at 0x7FFFFFFF with bit8 set when ACC_SATURATE_EN is defined.
- Assert axis_rst_n low mid-run -> all outputs return to reset values asynchronously; a fresh run then passes.
